vga_fb_pixel_fetch: RTL and testbench
=====================================

// Module: vga_fb_pixel_fetch
// PURPOSE
//  Streams pixels from the frame-buffer BRAM (read port, 1-cycle registered read latency) to the VGA colour output.
//  Generates word addresses from line/frame timing, prefetches one word ahead, unpacks packed pixels and
//  replicates each frame-buffer pixel SCALE x SCALE. Sits between the BRAM read port and the VGA sync/colour stage.
// PARAMETERS
//  H_PIXELS      640  active pixels per display line
//  V_LINES       480  active display lines per frame
//  SCALE         4    pixel replication factor, both axes (H_PIXELS, V_LINES divisible by SCALE; SCALE*PIX_PER_WORD >= 2)
//  PIX_DEPTH     3    bits per pixel
//  PIX_PER_WORD  6    pixels per BRAM word (word width = PIX_DEPTH*PIX_PER_WORD = 18)
//  ADDR_W        derived: $clog2(FB_H*WORDS_PER_LINE); FB_W=H_PIXELS/SCALE, FB_H=V_LINES/SCALE, WORDS_PER_LINE=ceil(FB_W/PIX_PER_WORD)
// PORTS
//  clka          in   1          clock
//  rst           in   1          synchronous reset, active-high
//  frame_start_i in   1          1-cycle pulse in vertical blanking; next line_start_i is row 0
//  line_start_i  in   1          1-cycle pulse in horizontal blanking, >=4 clka before first consume of the line
//  pix_tick_i    in   1          pixel-rate enable
//  active_i      in   1          current pixel is in active video; consume = pix_tick_i & active_i
//  bram_en_o     out  1          BRAM read enable
//  bram_addr_o   out  ADDR_W     BRAM word address
//  bram_dout_i   in   PIX_DEPTH*PIX_PER_WORD  BRAM read data, valid the cycle after bram_en_o
//  pixel_o       out  PIX_DEPTH  pixel value
//  pixel_vld_o   out  1          pixel_o valid (1 cycle after consume)
// BEHAVIOUR
//  Reset: state IDLE; pixel_o=0, pixel_vld_o=0, bram_en_o=0, bram_addr_o=0, all counters/buffers/flags 0. Reset mid-line aborts.
//  FSM: IDLE -(line_start)-> PRIME_A -> PRIME_B -> PRIME_C -> STREAM -(H_PIXELS consumes)-> LINE_DONE -(line_start)-> PRIME_A.
//   PRIME_A: en=1, addr=base. PRIME_B: en=1, addr=base+1; cur_word<=dout. PRIME_C: nxt_word<=dout, nxt_vld=1.
//  Rows: on line_start, sub_line++ (0..SCALE-1); on wrap row++; row saturates at FB_H-1. base=row*WORDS_PER_LINE.
//  STREAM consume: pixel_o<=cur_word[pix_idx*PIX_DEPTH +: PIX_DEPTH] (pixel 0 at LSBs), pixel_vld_o<=1 next cycle.
//   rep_cnt 0..SCALE-1; on wrap pix_idx++; on pix_idx wrap at PIX_PER_WORD-1: cur_word<=nxt_word, nxt_vld<=0,
//   read issued same cycle at rd_addr=base+2+k (k=words consumed-1), nxt_word<=dout and nxt_vld<=1 next cycle.
//  Partial last word (FB_W mod PIX_PER_WORD != 0): unused upper pixels never output; line ends on H_PIXELS count.
//  Address wrap: rd_addr beyond FB_H*WORDS_PER_LINE-1 wraps to 0; over-line prefetch is harmless and discarded.
//  Consume outside STREAM (IDLE/PRIME/LINE_DONE): pixel_o=0, pixel_vld_o=1. No consume: pixel_vld_o=0, pixel_o holds.
//  line_start during PRIME_*/STREAM: abort, counts as new line, re-enter PRIME_A.
//  frame_start: row=0, sub_line=0, go to IDLE; same cycle as line_start: frame_start first, that line is row 0.
//  bram_en_o is 0 in all cycles other than prime and swap reads.
// CONFIGURATION
//  VGA_FETCH_UNDERRUN_EN defined: adds output underrun_o (1 bit, reset 0, sticky until rst/frame_start) set when
//   swap occurs with nxt_vld=0, consume occurs in PRIME_* state, or line_start arrives during PRIME_*.
//  Not defined: port absent, conditions silently ignored, behaviour otherwise identical.
// STRUCTURE
//  vga_pkg: fetch_state_t enum, FB_W/FB_H/WORDS_PER_LINE/ADDR_W localparam functions.
//  Sub-module vga_pixel_unpack: cur_word/nxt_word buffers, pix_idx/rep_cnt, pixel mux; top holds FSM and addressing.
// TESTING
//  Reset then frame_start, line_start, 640 consumes with word0=18'o765432 -> pixels 2,3,4,5,6,7 each 4x, bram_addr 0,1,2..
//  4 line_starts -> rows 0,0,0,0 (addr base 0); 5th -> base 27; 481st line -> base stays 119*27.
//  pix_tick every cycle, full line -> no gap, pixel_vld_o continuous 640 cycles, underrun_o stays 0.
//  Last word of line (word 26): only pixels 0..3 output (160=26*6+4), next line restarts at pixel 0 of new base.
//  line_start 2 cycles before consume (EN defined) -> pixel_o=0 for early consumes, underrun_o=1 until frame_start.
//  rst asserted mid-STREAM -> next cycle bram_en_o=0, pixel_vld_o=0, state IDLE; consumes ignored until line_start.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared fetch FSM state type and frame-buffer geometry helpers
package vga_pkg;
  typedef enum logic [2:0] {IDLE, PRIME_A, PRIME_B, PRIME_C, STREAM, LINE_DONE} fetch_state_t;
  function automatic int fb_w(int h_pixels, int scale);
    return h_pixels / scale;
  endfunction
  function automatic int fb_h(int v_lines, int scale);
    return v_lines / scale;
  endfunction
  function automatic int words_per_line(int w, int ppw);
    return (w + ppw - 1) / ppw;
  endfunction
  function automatic int addr_w(int h_pixels, int v_lines, int scale, int ppw);
    return $clog2(fb_h(v_lines, scale) * words_per_line(fb_w(h_pixels, scale), ppw));
  endfunction
endpackage

// File: rtl/vga_pixel_unpack.sv
// vga_pixel_unpack: current/next word buffers, pixel index and replication counters, pixel output mux
// Ports: clka, rst; clr (new line), ld_cur/ld_nxt (prime loads), consume, stream, adv (counted consume);
// dout (BRAM data); swap (word exhausted, issue refill); pixel_o, pixel_vld_o; nxt_vld with VGA_FETCH_UNDERRUN_EN.
module vga_pixel_unpack #(
  parameter int SCALE = 4,
  parameter int PIX_DEPTH = 3,
  parameter int PIX_PER_WORD = 6
) (
  input  logic                              clka,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              ld_cur,
  input  logic                              ld_nxt,
  input  logic                              consume,
  input  logic                              stream,
  input  logic                              adv,
  input  logic [PIX_DEPTH*PIX_PER_WORD-1:0] dout,
  output logic                              swap,
  output logic [PIX_DEPTH-1:0]              pixel_o,
  output logic                              pixel_vld_o
`ifdef VGA_FETCH_UNDERRUN_EN
  , output logic                            nxt_vld
`endif
);
  localparam int RW = $clog2(SCALE + 1);
  localparam int IW = $clog2(PIX_PER_WORD + 1);
  logic [PIX_DEPTH*PIX_PER_WORD-1:0] cur_word, nxt_word;
  logic [IW-1:0] pix_idx;
  logic [RW-1:0] rep_cnt;
  logic rep_last, idx_last, fill;
  assign rep_last = rep_cnt == RW'(SCALE - 1);
  assign idx_last = pix_idx == IW'(PIX_PER_WORD - 1);
  assign swap = adv & rep_last & idx_last;
  // fill marks the cycle the swap read's data arrives on dout
  always_ff @(posedge clka)
    if (rst) begin
      cur_word <= '0;
      nxt_word <= '0;
      pix_idx <= '0;
      rep_cnt <= '0;
      fill <= 1'b0;
      pixel_o <= '0;
      pixel_vld_o <= 1'b0;
    end else begin
      pixel_vld_o <= consume;
      if (consume) pixel_o <= stream ? cur_word[pix_idx*PIX_DEPTH +: PIX_DEPTH] : '0;
      fill <= swap & ~clr;
      if (clr) begin
        rep_cnt <= '0;
        pix_idx <= '0;
      end else if (adv) begin
        rep_cnt <= rep_last ? '0 : rep_cnt + 1'b1;
        if (rep_last) pix_idx <= idx_last ? '0 : pix_idx + 1'b1;
      end
      if (ld_cur) cur_word <= dout;
      else if (swap) cur_word <= nxt_word;
      if (ld_nxt | fill) nxt_word <= dout;
    end
`ifdef VGA_FETCH_UNDERRUN_EN
  always_ff @(posedge clka)
    if (rst | clr | swap) nxt_vld <= 1'b0;
    else if (ld_nxt | fill) nxt_vld <= 1'b1;
`endif
endmodule

// File: rtl/vga_fb_pixel_fetch.sv
// vga_fb_pixel_fetch: streams scaled frame-buffer pixels from BRAM to the VGA colour path
// Ports: clka, rst (sync, active-high); frame_start_i, line_start_i, pix_tick_i, active_i (timing);
// bram_en_o, bram_addr_o, bram_dout_i (BRAM read port, 1-cycle latency); pixel_o, pixel_vld_o (colour out);
// underrun_o (sticky) only when VGA_FETCH_UNDERRUN_EN is defined.
module vga_fb_pixel_fetch import vga_pkg::*; #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES = 480,
  parameter int SCALE = 4,
  parameter int PIX_DEPTH = 3,
  parameter int PIX_PER_WORD = 6,
  parameter int ADDR_W = addr_w(H_PIXELS, V_LINES, SCALE, PIX_PER_WORD)
) (
  input  logic                              clka,
  input  logic                              rst,
  input  logic                              frame_start_i,
  input  logic                              line_start_i,
  input  logic                              pix_tick_i,
  input  logic                              active_i,
  output logic                              bram_en_o,
  output logic [ADDR_W-1:0]                 bram_addr_o,
  input  logic [PIX_DEPTH*PIX_PER_WORD-1:0] bram_dout_i,
  output logic [PIX_DEPTH-1:0]              pixel_o,
  output logic                              pixel_vld_o
`ifdef VGA_FETCH_UNDERRUN_EN
  , output logic                            underrun_o
`endif
);
  localparam int FB_H = fb_h(V_LINES, SCALE);
  localparam int WPL = words_per_line(fb_w(H_PIXELS, SCALE), PIX_PER_WORD);
  localparam int RW = $clog2(FB_H + 1);
  localparam int SW = $clog2(SCALE + 1);
  localparam int CW = $clog2(H_PIXELS + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_H * WPL - 1);
  fetch_state_t state, state_n;
  logic [RW-1:0] row, row_eff;
  logic [SW-1:0] sub_line, sub_eff;
  logic [ADDR_W-1:0] base, rd_addr;
  logic [CW-1:0] pix_cnt;
  logic consume, adv, swap, sub_wrap;
  function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] a);
    return a == LAST_ADDR ? '0 : a + 1'b1;
  endfunction
  assign consume = pix_tick_i & active_i;
  assign adv = consume & (state == STREAM) & ~line_start_i & ~frame_start_i;
  // frame_start in the same cycle as line_start makes that line row 0
  assign row_eff = frame_start_i ? '0 : row;
  assign sub_eff = frame_start_i ? '0 : sub_line;
  assign sub_wrap = sub_eff == SW'(SCALE - 1);
  assign bram_en_o = state == PRIME_A || state == PRIME_B || swap;
  assign bram_addr_o = state == PRIME_A ? base : state == PRIME_B ? inc(base) : rd_addr;
  always_comb begin
    state_n = state;
    state_n = line_start_i ? PRIME_A :
              frame_start_i ? IDLE :
              state == PRIME_A ? PRIME_B :
              state == PRIME_B ? PRIME_C :
              state == PRIME_C ? STREAM :
              (adv && pix_cnt == CW'(H_PIXELS - 1)) ? LINE_DONE : state;
  end
  always_ff @(posedge clka) state <= rst ? IDLE : state_n;
  // the line fetches with the row in effect at line_start; counters then advance for the next line
  always_ff @(posedge clka)
    if (rst) begin
      row <= '0;
      sub_line <= '0;
      base <= '0;
      rd_addr <= '0;
      pix_cnt <= '0;
    end else begin
      if (line_start_i) begin
        base <= ADDR_W'(row_eff * WPL);
        sub_line <= sub_wrap ? '0 : sub_eff + 1'b1;
        row <= (sub_wrap && row_eff != RW'(FB_H - 1)) ? row_eff + 1'b1 : row_eff;
        pix_cnt <= '0;
      end else if (frame_start_i) begin
        row <= '0;
        sub_line <= '0;
      end
      if (adv) pix_cnt <= pix_cnt + 1'b1;
      if (state == PRIME_C) rd_addr <= inc(inc(base));
      else if (swap) rd_addr <= inc(rd_addr);
    end
`ifdef VGA_FETCH_UNDERRUN_EN
  logic nxt_vld, prime;
  assign prime = state == PRIME_A || state == PRIME_B || state == PRIME_C;
  always_ff @(posedge clka)
    if (rst || frame_start_i) underrun_o <= 1'b0;
    else if ((swap && !nxt_vld) || (prime && (consume || line_start_i))) underrun_o <= 1'b1;
`endif
  vga_pixel_unpack #(
    .SCALE(SCALE),
    .PIX_DEPTH(PIX_DEPTH),
    .PIX_PER_WORD(PIX_PER_WORD)
  ) u_unpack (
    .clka(clka),
    .rst(rst),
    .clr(line_start_i),
    .ld_cur(state == PRIME_B),
    .ld_nxt(state == PRIME_C),
    .consume(consume),
    .stream(state == STREAM),
    .adv(adv),
    .dout(bram_dout_i),
    .swap(swap),
    .pixel_o(pixel_o),
    .pixel_vld_o(pixel_vld_o)
`ifdef VGA_FETCH_UNDERRUN_EN
    , .nxt_vld(nxt_vld)
`endif
  );
endmodule

// File: tb/tb_vga_fb_pixel_fetch.sv
// tb_vga_fb_pixel_fetch: directed table-driven bench for vga_fb_pixel_fetch
module tb_vga_fb_pixel_fetch;
  typedef struct {
    int slot;
    int px;
    int exp;
  } vec_t;
  logic clka = 1'b0;
  logic rst = 1'b1;
  logic frame_start_i = 1'b0;
  logic line_start_i = 1'b0;
  logic pix_tick_i = 1'b0;
  logic active_i = 1'b0;
  logic bram_en_o;
  logic [11:0] bram_addr_o;
  logic [17:0] bram_dout_i = '0;
  logic [2:0] pixel_o;
  logic pixel_vld_o;
`ifdef VGA_FETCH_UNDERRUN_EN
  logic underrun_o;
`endif
  logic [17:0] mem [0:4095];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic mon = 1'b0;
  int addr_q[$];
  int pix_q[$];
  int vfirst, vlast;
  int lp [3][640];
  vec_t tbl [13];

  vga_fb_pixel_fetch dut (
    .clka(clka),
    .rst(rst),
    .frame_start_i(frame_start_i),
    .line_start_i(line_start_i),
    .pix_tick_i(pix_tick_i),
    .active_i(active_i),
    .bram_en_o(bram_en_o),
    .bram_addr_o(bram_addr_o),
    .bram_dout_i(bram_dout_i),
    .pixel_o(pixel_o),
    .pixel_vld_o(pixel_vld_o)
`ifdef VGA_FETCH_UNDERRUN_EN
    , .underrun_o(underrun_o)
`endif
  );

  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;
  always @(posedge clka) if (bram_en_o) bram_dout_i <= mem[bram_addr_o];
  always @(negedge clka)
    if (mon) begin
      if (bram_en_o) addr_q.push_back(int'(bram_addr_o));
      if (pixel_vld_o) begin
        if (pix_q.size() == 0) vfirst = cyc;
        vlast = cyc;
        pix_q.push_back(int'(pixel_o));
      end
    end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int exp_pix(int base, int px);
    return (base + px / 24 + (px / 4) % 6 + 2) % 8;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic pulse_fs();
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
  endtask

  task automatic pulse_ls();
    line_start_i = 1'b1;
    tick();
    line_start_i = 1'b0;
  endtask

  task automatic short_line(input int exp_base);
    pulse_ls();
    @(negedge clka);
    chk("line_base", bram_en_o ? 32'(bram_addr_o) : 32'hFFFF_FFFF, exp_base);
    repeat (4) tick();
  endtask

  task automatic full_line(input int slot, input int exp_base);
    int bad, first;
    addr_q.delete();
    pix_q.delete();
    mon = 1'b1;
    pulse_ls();
    repeat (3) tick();
    pix_tick_i = 1'b1;
    active_i = 1'b1;
    repeat (640) tick();
    pix_tick_i = 1'b0;
    active_i = 1'b0;
    repeat (3) tick();
    mon = 1'b0;
    chk("pix_count", pix_q.size(), 640);
    chk("vld_run", vlast - vfirst + 1, 640);
    chk("read_count", addr_q.size(), 28);
    for (int k = 0; k < 28; k++)
      chk("read_addr", k < addr_q.size() ? addr_q[k] : -1, (exp_base + k) % 3240);
    bad = 0;
    first = -1;
    for (int i = 0; i < 640; i++) begin
      lp[slot][i] = i < pix_q.size() ? pix_q[i] : -1;
      if (lp[slot][i] != exp_pix(exp_base, i)) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    if (bad != 0) $display("first bad pixel index %0d on line slot %0d", first, slot);
    chk("line_pixel_errors", bad, 0);
    @(negedge clka);
    chk("idle_vld", pixel_vld_o, 0);
    chk("pixel_hold", pixel_o, exp_pix(exp_base, 639));
`ifdef VGA_FETCH_UNDERRUN_EN
    chk("underrun_clean", underrun_o, 0);
`endif
  endtask

  initial begin
    int sl, b;
    for (int a = 0; a < 4096; a++)
      for (int j = 0; j < 6; j++) mem[a][j*3 +: 3] = 3'((a + j + 2) % 8);
    tbl = '{'{0, 0, 2}, '{0, 3, 2}, '{0, 4, 3}, '{0, 23, 7}, '{0, 24, 3}, '{0, 632, 6}, '{0, 639, 7},
            '{1, 0, 5}, '{1, 24, 6}, '{1, 639, 2}, '{2, 0, 7}, '{2, 25, 0}, '{2, 639, 4}};
    repeat (3) tick();
    @(negedge clka);
    chk("rst_en", bram_en_o, 0);
    chk("rst_addr", bram_addr_o, 0);
    chk("rst_vld", pixel_vld_o, 0);
    chk("rst_pix", pixel_o, 0);
`ifdef VGA_FETCH_UNDERRUN_EN
    chk("rst_underrun", underrun_o, 0);
`endif
    tick();
    rst = 1'b0;
    pulse_fs();
    tick();
    sl = 0;
    for (int l = 1; l <= 481; l++) begin
      b = ((l - 1) / 4 > 119 ? 119 : (l - 1) / 4) * 27;
      if (l == 1 || l == 5 || l == 481) begin
        full_line(sl, b);
        sl++;
      end else short_line(b);
    end
    for (int i = 0; i < 13; i++) chk("table_pixel", lp[tbl[i].slot][tbl[i].px], tbl[i].exp);
    frame_start_i = 1'b1;
    line_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    line_start_i = 1'b0;
    @(negedge clka);
    chk("fs_ls_base", bram_en_o ? 32'(bram_addr_o) : 32'hFFFF_FFFF, 0);
    repeat (4) tick();
    repeat (3) short_line(0);
    short_line(27);
    pulse_fs();
    pix_q.delete();
    pulse_ls();
    tick();
    mon = 1'b1;
    pix_tick_i = 1'b1;
    active_i = 1'b1;
    repeat (10) tick();
    pix_tick_i = 1'b0;
    active_i = 1'b0;
    tick();
    mon = 1'b0;
    chk("early_count", pix_q.size(), 10);
    chk("early_pix0", pix_q.size() > 0 ? pix_q[0] : -1, 0);
    chk("early_pix1", pix_q.size() > 1 ? pix_q[1] : -1, 0);
    chk("early_pix2", pix_q.size() > 2 ? pix_q[2] : -1, 2);
    chk("early_pix5", pix_q.size() > 5 ? pix_q[5] : -1, 2);
    chk("early_pix6", pix_q.size() > 6 ? pix_q[6] : -1, 3);
`ifdef VGA_FETCH_UNDERRUN_EN
    @(negedge clka);
    chk("underrun_set", underrun_o, 1);
    tick();
    @(negedge clka);
    chk("underrun_sticky", underrun_o, 1);
`endif
    pulse_fs();
    @(negedge clka);
`ifdef VGA_FETCH_UNDERRUN_EN
    chk("underrun_cleared", underrun_o, 0);
`endif
    pulse_ls();
    repeat (3) tick();
    pix_tick_i = 1'b1;
    active_i = 1'b1;
    repeat (100) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clka);
    chk("rst_mid_en", bram_en_o, 0);
    chk("rst_mid_vld", pixel_vld_o, 0);
    repeat (30) begin
      tick();
      @(negedge clka);
      if (bram_en_o) chk("idle_no_read", bram_en_o, 0);
    end
    chk("idle_consume_vld", pixel_vld_o, 1);
    chk("idle_consume_pix", pixel_o, 0);
    pix_tick_i = 1'b0;
    active_i = 1'b0;
    tick();
    short_line(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
